// File: rtl/rv_intr_ctrl.sv
// rv_intr_ctrl - interrupt controller for the RV32I SoC.
//
// Purpose:
//   Collects N_SRC external interrupt lines, synchronises them, latches them
//   as edge- or level-triggered pending bits, masks them with ENABLE, and
//   presents a single irq line plus a claim/complete register port to the
//   core. It also raises a wake request while the core sits in WFI.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous, active-low reset
//   i_intr_in    raw interrupt lines, asynchronous to clk (ID k+1 = bit k)
//   i_wfi_in     high while the core sits in WFI
//   i_bus_req    register access strobe, one cycle per access
//   i_bus_we     1 = write, 0 = read
//   i_bus_addr   byte address, word aligned
//   i_bus_wdata  write data
//   o_bus_rdata  read data, valid while o_bus_rvalid = 1, held until next read
//   o_bus_rvalid one-cycle pulse, one cycle after a read strobe
//   o_irq        a claimable interrupt exists (registered)
//   o_wake       wake request during WFI (registered)
//
// Register map: 0x00 PENDING (W1C on edge-mode bits), 0x04 ENABLE,
//   0x08 TRIGGER (1 = rising edge, 0 = high level), 0x0C CLAIM
//   (read = claim, write = complete), 0x10 INSERV. Other addresses read 0.

module rv_intr_ctrl #(
  parameter int N_SRC = 5,
  parameter int SYNC  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  i_intr_in,
  input  logic              i_wfi_in,
  input  logic              i_bus_req,
  input  logic              i_bus_we,
  input  logic [4:0]        i_bus_addr,
  input  logic [31:0]       i_bus_wdata,
  output logic [31:0]       o_bus_rdata,
  output logic              o_bus_rvalid,
  output logic              o_irq,
  output logic              o_wake
);

  localparam logic [4:0] ADDR_PENDING = 5'h00;
  localparam logic [4:0] ADDR_ENABLE  = 5'h04;
  localparam logic [4:0] ADDR_TRIGGER = 5'h08;
  localparam logic [4:0] ADDR_CLAIM   = 5'h0C;
  localparam logic [4:0] ADDR_INSERV  = 5'h10;

  logic [N_SRC-1:0] r_sync [SYNC];
  logic [N_SRC-1:0] r_prev;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_enable;
  logic [N_SRC-1:0] r_trigger;
  logic [N_SRC-1:0] r_inserv;
  logic [31:0]      r_rdata;
  logic             r_rvalid;
  logic             r_irq;
  logic             r_wake;

  logic [N_SRC-1:0] w_level;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_claimable;
  logic [N_SRC-1:0] w_claimMask;
  logic [4:0]       w_claimId;
  logic [N_SRC-1:0] w_claimSet;
  logic [N_SRC-1:0] w_w1c;
  logic [N_SRC-1:0] w_done;
  logic [N_SRC-1:0] w_pendNext;
  logic [N_SRC-1:0] w_inservNext;
  logic             w_rdStb;
  logic             w_wrStb;
  logic [31:0]      w_rdMux;
  logic             w_unusedWdata;

  assign w_rdStb = i_bus_req & ~i_bus_we;
  assign w_wrStb = i_bus_req & i_bus_we;

  // Only the low N_SRC bits of write data carry register content.
  assign w_unusedWdata = ^i_bus_wdata[31:N_SRC];

  // Synchroniser chain followed by one extra register so a rising edge is
  // seen as synced-high while the delayed copy is still low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) r_sync[i] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= i_intr_in;
      for (int i = 1; i < SYNC; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[SYNC-1];
    end
  end

  assign w_level     = r_sync[SYNC-1];
  assign w_rise      = w_level & ~r_prev;
  assign w_claimable = r_pending & r_enable & ~r_inserv;

  // Fixed priority: scanning from the top down leaves the lowest ID winning.
  always_comb begin
    w_claimId   = '0;
    w_claimMask = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (w_claimable[k]) begin
        w_claimId      = 5'(k + 1);
        w_claimMask    = '0;
        w_claimMask[k] = 1'b1;
      end
    end
  end

  // A complete only touches the in-service bit of a valid ID; 0 or IDs past
  // N_SRC match nothing and fall through harmlessly.
  always_comb begin
    w_done = '0;
    for (int k = 0; k < N_SRC; k++) begin
      w_done[k] = w_wrStb && (i_bus_addr == ADDR_CLAIM) &&
                  (i_bus_wdata[4:0] == 5'(k + 1));
    end
  end

  assign w_claimSet = (w_rdStb && i_bus_addr == ADDR_CLAIM) ? w_claimMask : '0;
  assign w_w1c      = (w_wrStb && i_bus_addr == ADDR_PENDING) ?
                      i_bus_wdata[N_SRC-1:0] : '0;

  // Edge mode: a new edge beats both a W1C and a claim in the same cycle.
  // Level mode: pending simply tracks the synced line.
  assign w_pendNext   = (r_trigger & (w_rise | (r_pending & ~w_w1c & ~w_claimSet))) |
                        (~r_trigger & w_level);
  assign w_inservNext = (r_inserv | w_claimSet) & ~w_done;

  always_comb begin
    w_rdMux = '0;
    case (i_bus_addr)
      ADDR_PENDING: w_rdMux = 32'(r_pending);
      ADDR_ENABLE:  w_rdMux = 32'(r_enable);
      ADDR_TRIGGER: w_rdMux = 32'(r_trigger);
      ADDR_CLAIM:   w_rdMux = 32'(w_claimId);
      ADDR_INSERV:  w_rdMux = 32'(r_inserv);
      default:      w_rdMux = '0;
    endcase
  end

  // Source state, configuration and the registered bus/irq/wake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_enable  <= '0;
      r_trigger <= '0;
      r_inserv  <= '0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_irq     <= 1'b0;
      r_wake    <= 1'b0;
    end else begin
      r_pending <= w_pendNext;
      r_inserv  <= w_inservNext;
      if (w_wrStb && i_bus_addr == ADDR_ENABLE)  r_enable  <= i_bus_wdata[N_SRC-1:0];
      if (w_wrStb && i_bus_addr == ADDR_TRIGGER) r_trigger <= i_bus_wdata[N_SRC-1:0];
      r_rvalid <= w_rdStb;
      if (w_rdStb) r_rdata <= w_rdMux;
      r_irq  <= |w_claimable;
      // Wake deliberately ignores INSERV so a nested source can still wake.
      r_wake <= i_wfi_in & (|(r_pending & r_enable));
    end
  end

  assign o_bus_rdata  = r_rdata;
  assign o_bus_rvalid = r_rvalid;
  assign o_irq        = r_irq;
  assign o_wake       = r_wake;

endmodule
